full_adder_serial_param: RTL and testbench
==========================================

// Module: full_adder_serial_param
// PURPOSE
//  - Parametrised digit-serial adder: s = a + b + cin over WIDTH bits, DIGIT bits per clock.
//  - Successor to the combinational 4-bit adder. Trades latency for area on wide datapaths.
//  - Used where wide sums arrive infrequently. Start/busy/done handshake to the controlling FSM.
// PARAMETERS
//  - WIDTH  16  operand/sum width in bits
//  - DIGIT  4   bits added per cycle. WIDTH % DIGIT must be 0, otherwise elaboration error.
//  - NDIG   WIDTH/DIGIT  localparam, not overridable: number of RUN cycles
// PORTS
//  - clk     in   1      single clock, rising edge
//  - rst_n   in   1      asynchronous, active-low reset
//  - start   in   1      request. Sampled only in IDLE.
//  - a       in   WIDTH  operand A, captured on the accepting edge
//  - b       in   WIDTH  operand B, captured on the accepting edge
//  - cin     in   1      carry in, captured on the accepting edge
//  - busy    out  1      operation in progress
//  - done    out  1      one-cycle pulse. s/cout/ovf valid from this cycle.
//  - s       out  WIDTH  sum. Registered; held until the next completion.
//  - cout    out  1      carry out. Registered; held like s.
//  - ovf     out  1      signed overflow. Present only with FULL_ADDER_SERIAL_OVF_EN.
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; digit counter=0.
//  - States:
//    - IDLE: on an edge with start=1, capture a, b, cin into shift regs; counter=0; busy=1; go to RUN.
//    - RUN: each edge adds the low DIGIT bits of a_sh + b_sh + carry_q.
//      - Digit sum shifts into the top of sum_sh; a_sh/b_sh shift right by DIGIT.
//      - carry_q takes the digit carry; counter increments.
//      - Edge with counter==NDIG-1: load s <= final sum_sh, cout <= final carry; done=1; busy=0; go to IDLE.
//  - Latency: done is high in the cycle after the NDIG-th edge following the accepting edge.
//  - Throughput: one operation per NDIG+1 cycles. start is accepted again on the edge after done.
//  - done clears on the next edge unconditionally.
//  - start while busy=1 is ignored; operands are not re-captured and no error is flagged.
//  - start held high continuously: a new operation begins on every edge where state==IDLE.
//  - a, b, cin are don't-care outside the accepting edge.
//  - NDIG==1 (DIGIT==WIDTH): a single RUN edge; equivalent to a registered full-width adder.
//  - Carry ripples across digits through carry_q only. No combinational path from inputs to outputs.
//  - Reset mid-RUN aborts: no done pulse; outputs return to reset values.
//  - Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of the true sum.
// CONFIGURATION
//  - Macro FULL_ADDER_SERIAL_OVF_EN defined:
//    - Adds port ovf and a registered MSB-carry-in flag.
//    - ovf = carry into MSB XOR carry out of MSB, loaded with s, held like s, reset 0.
//  - Macro undefined: ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package fa_pkg:
//    - state encoding localparams FA_IDLE=1'b0, FA_RUN=1'b1
//    - clog2-based counter-width function
//  - One sub-module: fa_digit_add (DIGIT-bit combinational add, inputs a, b, cin; outputs s, cout).
//    - Instantiated once in the RUN datapath.
//  - The top holds the FSM, counter, shift registers and output registers.
// TESTING
//  - Reset: rst_n=0 with start=1 and a/b toggling -> busy=0, done=0, s=0, cout=0 throughout. Release -> IDLE.
//  - WIDTH=16, DIGIT=4: a=16'h1234, b=16'h4321, cin=0 -> done exactly 4 cycles after the accepting edge;
//    s=16'h5555, cout=0.
//  - Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1 (carry crosses all 4 digits).
//  - Busy rule: start with a=16'h0001, b=16'h0001; re-assert start with a=16'hFFFF during RUN ->
//    s=16'h0002, one done pulse, busy never drops early.
//  - Abort: assert rst_n=0 in the 2nd RUN cycle, release, run a=16'h00F0, b=16'h000F ->
//    no done for the aborted op; s=16'h00FF.
//  - Exhaustive and optional feature:
//    - WIDTH=4 with DIGIT=1,2,4: sweep all a, b, cin (512 cases) -> {cout,s}==a+b+cin.
//    - With OVF_EN: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, cout=0.
//    - With OVF_EN: a=16'h8000, b=16'h8000 -> s=0, cout=1, ovf=1.

Source files
------------

// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared state encoding and counter sizing for the digit-serial adder
package fa_pkg;

    // FSM states: IDLE waits for start, RUN adds one digit per clock
    typedef enum logic {
        FA_IDLE = 1'b0,
        FA_RUN  = 1'b1
    } fa_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit
    function automatic int fa_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa_digit_add.sv
// rtl/fa_digit_add.sv - DIGIT-bit combinational add with carry in and carry out
module fa_digit_add #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    // One extra bit of headroom captures the digit carry
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/full_adder_serial_param.sv
// rtl/full_adder_serial_param.sv - digit-serial WIDTH-bit adder, signed overflow flag under FULL_ADDER_SERIAL_OVF_EN
module full_adder_serial_param
    import fa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef FULL_ADDER_SERIAL_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = fa_cnt_w(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    // Operand width must split into whole digits
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("full_adder_serial_param: WIDTH must be a multiple of DIGIT");
    end

    fa_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic [WIDTH-1:0] sum_next;

`ifdef FULL_ADDER_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_cin;
`endif

    fa_digit_add #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    // New digit enters at the top so after NDIG shifts the sum is LSB-aligned
    if (NDIG == 1) begin : g_single
        assign sum_next = dig_s;
    end else begin : g_multi
        assign sum_next = {dig_s, sum_sh_q[WIDTH-1:DIGIT]};
    end

`ifdef FULL_ADDER_SERIAL_OVF_EN
    // Carry into the MSB recovered from its sum bit; only meaningful on the final digit
    assign msb_cin = dig_s[DIGIT-1] ^ a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1];
`endif

    // Next-state, datapath shift and result load
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        s_d      = s_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
`ifdef FULL_ADDER_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            FA_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = FA_RUN;
                end
            end
            FA_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                sum_sh_d = sum_next;
                carry_d  = dig_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    s_d     = sum_next;
                    cout_d  = dig_c;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = FA_IDLE;
`ifdef FULL_ADDER_SERIAL_OVF_EN
                    ovf_d   = msb_cin ^ dig_c;
`endif
                end
            end
            default: state_d = FA_IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FA_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FULL_ADDER_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
`ifdef FULL_ADDER_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == FA_RUN);
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
`ifdef FULL_ADDER_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_serial_param.sv
// tb/tb_full_adder_serial_param.sv - directed checks of the digit-serial adder, FULL_ADDER_SERIAL_OVF_EN adds overflow cases
module tb_full_adder_serial_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done, cout;
    logic [15:0] s;

    logic        sw_start;
    logic [3:0]  sw_a, sw_b;
    logic        sw_cin;
    logic        busy1, done1, c1, busy2, done2, c2, busy4, done4, c4;
    logic [3:0]  s1, s2, s4;

`ifdef FULL_ADDER_SERIAL_OVF_EN
    logic        ovf, ovf1, ovf2, ovf4;
`endif

    int checks   = 0;
    int failures = 0;
    int busy_drops;

    always #5 clk = ~clk;

    full_adder_serial_param #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s),
`ifdef FULL_ADDER_SERIAL_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    full_adder_serial_param #(.WIDTH(4), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a), .b(sw_b), .cin(sw_cin),
        .busy(busy1), .done(done1), .s(s1),
`ifdef FULL_ADDER_SERIAL_OVF_EN
        .ovf(ovf1),
`endif
        .cout(c1)
    );

    full_adder_serial_param #(.WIDTH(4), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a), .b(sw_b), .cin(sw_cin),
        .busy(busy2), .done(done2), .s(s2),
`ifdef FULL_ADDER_SERIAL_OVF_EN
        .ovf(ovf2),
`endif
        .cout(c2)
    );

    full_adder_serial_param #(.WIDTH(4), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a), .b(sw_b), .cin(sw_cin),
        .busy(busy4), .done(done4), .s(s4),
`ifdef FULL_ADDER_SERIAL_OVF_EN
        .ovf(ovf4),
`endif
        .cout(c4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the 16-bit DUT; returns edges from accept to done (20 = timeout)
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          output int lat);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        lat   = 0;
        busy_drops = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) busy_drops++;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        int nd;
        logic [4:0] e;

        rst_n    = 1'b0;
        start    = 1'b1;
        a        = 16'h0;
        b        = 16'h0;
        cin      = 1'b0;
        sw_start = 1'b0;
        sw_a     = '0;
        sw_b     = '0;
        sw_cin   = 1'b0;

        // Reset holds everything quiet even with start asserted and operands toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom);
            b = 16'($urandom);
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_s",    32'(s),    32'(0));
            check("rst_cout", 32'(cout), 32'(0));
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'(0));

        // Basic add, no carries across digits
        run_op(16'h1234, 16'h4321, 1'b0, lat);
        check("basic_lat",   32'(lat),        32'(4));
        check("basic_s",     32'(s),          32'h5555);
        check("basic_cout",  32'(cout),       32'(0));
        check("basic_busy",  32'(busy),       32'(0));
        check("basic_drops", 32'(busy_drops), 32'(0));
`ifdef FULL_ADDER_SERIAL_OVF_EN
        check("basic_ovf",   32'(ovf),        32'(0));
`endif
        @(posedge clk); #1;
        check("done_clear",  32'(done),       32'(0));
        check("s_held",      32'(s),          32'h5555);

        // Carry born in digit 0 must ripple through all four digits
        run_op(16'hFFFF, 16'h0000, 1'b1, lat);
        check("ripple_lat",  32'(lat),  32'(4));
        check("ripple_s",    32'(s),    32'h0000);
        check("ripple_cout", 32'(cout), 32'(1));

        // start during RUN is ignored
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF;
        nd = 0;
        busy_drops = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
            if (i < 3 && !busy) busy_drops++;
            if (i == 1) start = 1'b0;
        end
        check("busyrule_done_cnt", 32'(nd),         32'(1));
        check("busyrule_s",        32'(s),          32'h0002);
        check("busyrule_cout",     32'(cout),       32'(0));
        check("busyrule_drops",    32'(busy_drops), 32'(0));

        // Reset in the 2nd RUN cycle aborts without a done pulse
        start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_s",    32'(s),    32'(0));
        check("abort_cout", 32'(cout), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'(0));
        run_op(16'h00F0, 16'h000F, 1'b0, lat);
        check("after_abort_lat", 32'(lat), 32'(4));
        check("after_abort_s",   32'(s),   32'h00FF);

        // Sign-boundary cases
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        check("pos_ovf_s",    32'(s),    32'h8000);
        check("pos_ovf_cout", 32'(cout), 32'(0));
`ifdef FULL_ADDER_SERIAL_OVF_EN
        check("pos_ovf_ovf",  32'(ovf),  32'(1));
`endif
        run_op(16'h8000, 16'h8000, 1'b0, lat);
        check("neg_ovf_s",    32'(s),    32'h0000);
        check("neg_ovf_cout", 32'(cout), 32'(1));
`ifdef FULL_ADDER_SERIAL_OVF_EN
        check("neg_ovf_ovf",  32'(ovf),  32'(1));
`endif

        // start held high: accept at edges 0, 5, 10 -> dones after edges 4 and 9
        start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        start = 1'b0;
        check("backtoback_done_cnt", 32'(nd), 32'(2));
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check("backtoback_timeout", 32'(lat < 10), 32'(1));
        check("backtoback_s",       32'(s),        32'h0003);

        // Exhaustive 4-bit sweep across three digit sizes
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    sw_a     = 4'(ai);
                    sw_b     = 4'(bi);
                    sw_cin   = 1'(ci);
                    sw_start = 1'b1;
                    @(posedge clk); #1;
                    sw_start = 1'b0;
                    repeat (5) begin
                        @(posedge clk); #1;
                    end
                    e = 5'(ai + bi + ci);
                    check($sformatf("sweep_d1_%0d_%0d_%0d", ai, bi, ci), 32'({c1, s1}), 32'(e));
                    check($sformatf("sweep_d2_%0d_%0d_%0d", ai, bi, ci), 32'({c2, s2}), 32'(e));
                    check($sformatf("sweep_d4_%0d_%0d_%0d", ai, bi, ci), 32'({c4, s4}), 32'(e));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
